led_matrix_page_scanner: RTL and testbench
==========================================

Name: led_matrix_page_scanner

Overview:
Parametrised successor to the fixed two-page status display. Time-multiplexes up to PAGES bitmap pages (irrigation status, tank level, future sensors) onto one ROWS x COLS LED matrix. Features:
- Configurable dwell time per page.
- Per-page enable and blink.
- Hold/force page selection.
- Tear-free page switching, applied only at scan-frame boundaries.
- Built-in column-scan driver.

It sits between the status decoders and the matrix pins.

Parameters:
ROWS, 7, matrix rows (pixels per column)
COLS, 5, matrix columns (scan positions)
PAGES, 2, number of bitmap pages; min 1
DWELL_TICKS, 2, slow-tick pulses each page is shown before advancing; min 1
SCAN_DIV, 1000, clk cycles each column stays active; min 1
PW, $clog2(PAGES) (min 1), width of page index

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
slow_tick  in  1  slow timebase (nominally 1 Hz); asynchronous level, synchronised internally
page_data  in  PAGES*ROWS*COLS  pixel bitmaps; page p, column c, row r at bit p*ROWS*COLS + c*ROWS + r; 1 = LED on
page_enable  in  PAGES  1 = page takes part in rotation
page_blink  in  PAGES  1 = page blanks on alternate blink phases
hold  in  1  1 = freeze rotation on current page
force_en  in  1  1 = display force_page instead of rotating
force_page  in  PW  page shown while force_en=1
rows_out  out  ROWS  row drive, active-high
columns_out  out  COLS  column select, one-hot active-low
current_page  out  PW  page currently on the matrix

Behaviour:
- Reset (async assert, sync release): columns_out=all 1s, rows_out=0, current_page=0, pending page=0, dwell_cnt=0, col_idx=0, div_cnt=0, blink_phase=0, sync/edge FFs=0.
- Tick handling:
  - slow_tick passes through a 2-FF synchroniser plus edge detect.
  - tick_pulse is a 1-clk pulse on each rising edge.
  - Latency from slow_tick edge to tick_pulse: 3 clk.
- Blink: blink_phase toggles on every tick_pulse.
- Rotation (evaluated on tick_pulse only):
  - force_en=1: pending=force_page (values >= PAGES are clamped to PAGES-1); dwell_cnt=0.
  - Else if hold=1: no change; dwell_cnt keeps its value.
  - Else if page_enable[current_page]=0: pending = next enabled page immediately; dwell_cnt=0.
  - Else dwell_cnt increments. When it reaches DWELL_TICKS-1, the next tick sets pending = next enabled page after current (ascending, wrap PAGES-1 -> 0) and dwell_cnt=0.
  - If current_page is the only enabled page, pending stays on it.
  - If no page is enabled (and force_en=0), the display blanks (rows_out=0) and pending does not change.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1. On wrap, col_idx advances 0..COLS-1, then wraps to 0.
  - Frame boundary = col_idx wraps COLS-1 -> 0. current_page <= pending only at the frame boundary, so a frame never mixes pages.
- Outputs, registered, 1 clk after col_idx/div state:
  - columns_out = ~(1<<col_idx).
  - rows_out = page_data column slice for current_page, col_idx.
  - rows_out is forced to 0 when page_blink[current_page]=1 and blink_phase=1.
  - rows_out is also forced to 0 when no page is enabled and force_en=0.
  - Forced pages bypass page_enable.
- Column overlap: columns_out is never more than one-hot low in any cycle.
- Simultaneous events: a tick_pulse and a frame boundary in the same cycle transfer the old pending value; the new pending applies at the next frame.
- page_data is sampled live each column (not latched per frame).
- Reset mid-frame: outputs go blank immediately (async).

Test Plan:
- Defaults, SCAN_DIV=4, enables=2'b11. Release reset -> columns_out cycles 11110,11101,11011,10111,01111, each 4 clk. rows_out shows page 0 bits [6:0],[13:7]... current_page=0.
- Apply 2 slow_tick edges -> pending=1. current_page changes to 1 exactly at the next col_idx 4->0 wrap, never mid-frame. 2 more edges -> returns to 0.
- page_enable=2'b01 while current_page=1 -> at next tick, pending=0. Then after any number of ticks current_page stays 0.
- page_blink=2'b01, page 0 all ones -> rows_out=7'h7F and 7'h00 alternating on each tick. columns_out keeps scanning.
- hold=1 for 5 ticks -> current_page unchanged. force_en=1, force_page=1 -> page 1 shown after next tick and frame boundary, even with page_enable[1]=0.
- page_enable=0, force_en=0 -> rows_out=0 continuously. Assert reset_n=0 mid-column -> columns_out=5'b11111 and rows_out=0 in the same cycle, without waiting for clk.

Source files
------------

// File: rtl/led_matrix_page_scanner.sv
// Rotates PAGES bitmaps onto a ROWS x COLS LED matrix with a column-scan driver; page swaps land only on frame boundaries.
// Latency: outputs registered 1 clk after scan state, slow_tick edge acts 3 clk later; no backpressure, page_data sampled live.
module led_matrix_page_scanner #(
    parameter int ROWS        = 7,
    parameter int COLS        = 5,
    parameter int PAGES       = 2,
    parameter int DWELL_TICKS = 2,
    parameter int SCAN_DIV    = 1000,
    parameter int PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        slow_tick,
    input  logic [PAGES*ROWS*COLS-1:0]  page_data,
    input  logic [PAGES-1:0]            page_enable,
    input  logic [PAGES-1:0]            page_blink,
    input  logic                        hold,
    input  logic                        force_en,
    input  logic [PW-1:0]               force_page,
    output logic [ROWS-1:0]             rows_out,
    output logic [COLS-1:0]             columns_out,
    output logic [PW-1:0]               current_page
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    logic            sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic            tick_q, tick_d;
    logic            blink_q, blink_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic [PW-1:0]   cur_q, cur_d;
    logic [TW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   div_q, div_d;
    logic [COLS-1:0] cols_q, cols_d;
    logic [ROWS-1:0] rows_q, rows_d;

    logic            any_en;
    logic            found;
    logic [PW-1:0]   next_pg;
    logic [PW-1:0]   force_pg;

    always_comb begin
        sync1_d  = slow_tick;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        tick_d   = sync2_q & ~sync3_q;
        any_en   = |page_enable;

        // First enabled page after the current one; falls back to itself when alone.
        next_pg  = cur_q;
        found    = 1'b0;
        for (int k = 1; k <= PAGES; k++) begin
            if (!found && page_enable[(int'(cur_q) + k) % PAGES]) begin
                next_pg = PW'((int'(cur_q) + k) % PAGES);
                found   = 1'b1;
            end
        end
        force_pg = (int'(force_page) >= PAGES) ? PW'(PAGES - 1) : force_page;

        blink_d   = blink_q;
        pending_d = pending_q;
        dwell_d   = dwell_q;
        if (tick_q) begin
            blink_d = ~blink_q;
            if (force_en) begin
                pending_d = force_pg;
                dwell_d   = '0;
            end else if (hold || !any_en) begin
                pending_d = pending_q;
            end else if (!page_enable[cur_q]) begin
                pending_d = next_pg;
                dwell_d   = '0;
            end else if (dwell_q == TW'(DWELL_TICKS - 1)) begin
                pending_d = next_pg;
                dwell_d   = '0;
            end else begin
                dwell_d   = dwell_q + 1'b1;
            end
        end

        div_d = div_q + 1'b1;
        col_d = col_q;
        cur_d = cur_q;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                cur_d = pending_q;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        cols_d = ~(COLS'(1) << col_q);
        rows_d = page_data[(int'(cur_q) * COLS + int'(col_q)) * ROWS +: ROWS];
        if ((page_blink[cur_q] && blink_q) || (!any_en && !force_en))
            rows_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            tick_q    <= 1'b0;
            blink_q   <= 1'b0;
            pending_q <= '0;
            cur_q     <= '0;
            dwell_q   <= '0;
            col_q     <= '0;
            div_q     <= '0;
            cols_q    <= '1;
            rows_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            tick_q    <= tick_d;
            blink_q   <= blink_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            div_q     <= div_d;
            cols_q    <= cols_d;
            rows_q    <= rows_d;
        end
    end

    assign rows_out     = rows_q;
    assign columns_out  = cols_q;
    assign current_page = cur_q;

endmodule

// File: tb/tb_led_matrix_page_scanner.sv
// Directed bench for led_matrix_page_scanner with SCAN_DIV=4: a frame is 20 clk, swaps land on cycles 20k.
module tb_led_matrix_page_scanner;

    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int PAGES = 2;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       slow_tick = 1'b0;
    logic [PAGES*ROWS*COLS-1:0] page_data;
    logic [PAGES-1:0]           page_enable = 2'b11;
    logic [PAGES-1:0]           page_blink = 2'b00;
    logic                       hold = 1'b0;
    logic                       force_en = 1'b0;
    logic [0:0]                 force_page = 1'b0;
    logic [ROWS-1:0]            rows_out;
    logic [COLS-1:0]            columns_out;
    logic [0:0]                 current_page;

    led_matrix_page_scanner #(
        .ROWS(ROWS), .COLS(COLS), .PAGES(PAGES), .DWELL_TICKS(2), .SCAN_DIV(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .slow_tick(slow_tick),
        .page_data(page_data), .page_enable(page_enable), .page_blink(page_blink),
        .hold(hold), .force_en(force_en), .force_page(force_page),
        .rows_out(rows_out), .columns_out(columns_out), .current_page(current_page)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; edge n loads the outputs for column ((n-1)/4)%5.
    int cyc;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic at(input int n);
        int guard = 0;
        while (cyc < n && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) chk("sched", cyc, n);
    endtask

    task automatic do_tick(input int n);
        at(n);
        slow_tick = 1'b1;
        at(n + 3);
        slow_tick = 1'b0;
    endtask

    function automatic logic [4:0] col_exp(input int n);
        logic [4:0] one = 5'b00001;
        return ~(one << (((n - 1) / 4) % 5));
    endfunction

    function automatic logic [6:0] pix(input int p, input int c);
        logic [6:0] one = 7'h01;
        return (p != 0) ? (7'h70 | 7'(c)) : (one << c);
    endfunction

    initial begin
        for (int p = 0; p < PAGES; p++)
            for (int c = 0; c < COLS; c++)
                page_data[(p * COLS + c) * ROWS +: ROWS] = pix(p, c);

        #23;
        chk("rst_cols", 32'(columns_out), 32'h1F);
        chk("rst_rows", 32'(rows_out), 32'h00);
        chk("rst_page", 32'(current_page), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First frame: one-hot-low scan with page 0 columns, 4 clk each.
        for (int n = 1; n <= 20; n++) begin
            at(n);
            chk("scan_cols", 32'(columns_out), 32'(col_exp(n)));
            chk("scan_rows", 32'(rows_out), 32'(pix(0, (n - 1) / 4)));
        end
        chk("scan_page", 32'(current_page), 32'h0);

        // Two ticks arm page 1; it appears only at the cycle-40 wrap.
        do_tick(22);
        do_tick(34);
        at(38); chk("rot_pre38", 32'(current_page), 32'h0);
        at(39); chk("rot_pre39", 32'(current_page), 32'h0);
        at(40); chk("rot_swap_pg", 32'(current_page), 32'h1);
                chk("rot_last_col", 32'(rows_out), 32'(pix(0, 4)));
        at(41); chk("rot_new_rows", 32'(rows_out), 32'(pix(1, 0)));
                chk("rot_new_cols", 32'(columns_out), 32'h1E);

        do_tick(42);
        do_tick(54);
        at(59); chk("back_pre", 32'(current_page), 32'h1);
        at(60); chk("back_swap", 32'(current_page), 32'h0);
        at(61); chk("back_rows", 32'(rows_out), 32'(pix(0, 0)));

        // Disable page 1 while it is displayed: next tick pulls back to page 0.
        do_tick(62);
        do_tick(74);
        at(80); chk("dis_on1", 32'(current_page), 32'h1);
        at(81); page_enable = 2'b01;
        do_tick(82);
        at(99);  chk("dis_pre", 32'(current_page), 32'h1);
        at(100); chk("dis_swap", 32'(current_page), 32'h0);
        do_tick(102);
        do_tick(114);
        at(140); chk("dis_stay", 32'(current_page), 32'h0);
        at(141); chk("dis_rows", 32'(rows_out), 32'(pix(0, 0)));

        // Blink page 0 (all ones); blink phase is 1 after nine ticks.
        page_data[0 +: ROWS*COLS] = '1;
        page_blink = 2'b01;
        at(145); chk("blink_off", 32'(rows_out), 32'h00);
                 chk("blink_off_cols", 32'(columns_out), 32'(col_exp(145)));
        do_tick(146);
        at(152); chk("blink_on", 32'(rows_out), 32'h7F);
                 chk("blink_on_cols", 32'(columns_out), 32'(col_exp(152)));
        do_tick(158);
        at(164); chk("blink_off2", 32'(rows_out), 32'h00);
                 chk("blink_off2_cols", 32'(columns_out), 32'(col_exp(164)));

        // Hold across five ticks with both pages enabled.
        at(165);
        page_blink  = 2'b00;
        page_enable = 2'b11;
        hold        = 1'b1;
        do_tick(166);
        do_tick(178);
        do_tick(190);
        do_tick(202);
        do_tick(214);
        at(240); chk("hold_page", 32'(current_page), 32'h0);

        // Force a disabled page.
        at(241);
        page_enable = 2'b01;
        force_en    = 1'b1;
        force_page  = 1'b1;
        do_tick(242);
        at(259); chk("force_pre", 32'(current_page), 32'h0);
        at(260); chk("force_swap", 32'(current_page), 32'h1);
        at(261); chk("force_rows", 32'(rows_out), 32'(pix(1, 0)));
                 chk("force_cols", 32'(columns_out), 32'h1E);

        // No page enabled and no force: blank.
        at(262);
        page_enable = 2'b00;
        force_en    = 1'b0;
        for (int n = 264; n <= 280; n += 4) begin
            at(n);
            chk("blank_rows", 32'(rows_out), 32'h00);
        end

        // Async reset mid-column blanks without a clock edge.
        at(282); page_enable = 2'b11;
        at(286); chk("pre_rst_rows", 32'(rows_out), 32'(pix(1, 1)));
                 chk("pre_rst_cols", 32'(columns_out), 32'(col_exp(286)));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cols", 32'(columns_out), 32'h1F);
        chk("arst_rows", 32'(rows_out), 32'h00);
        chk("arst_page", 32'(current_page), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
